// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control/display bundle: start/stop/clear requests in,
// BCD digits and status flags out.
// Optional lap-hold signals exist only when LAP_HOLD_EN is defined.
interface stopwatch_ctrl_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic [3:0] units;
    logic [3:0] tens;
    logic [3:0] hundreds;
    logic [3:0] thousands;
    logic       running;
    logic       tick;
    logic       overflow;
`ifdef LAP_HOLD_EN
    logic       lap;
    logic       lap_active;

    modport master (
        output start, stop, clear, lap,
        input  units, tens, hundreds, thousands, running, tick, overflow, lap_active
    );
    modport slave (
        input  start, stop, clear, lap,
        output units, tens, hundreds, thousands, running, tick, overflow, lap_active
    );
`else
    modport master (
        output start, stop, clear,
        input  units, tens, hundreds, thousands, running, tick, overflow
    );
    modport slave (
        input  start, stop, clear,
        output units, tens, hundreds, thousands, running, tick, overflow
    );
`endif
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch run/pause/clear controller driving a four-digit cascaded BCD
// counter. A prescaler gated by the FSM produces the count-advance strobe.
// Optional lap-hold display freeze is enabled by defining LAP_HOLD_EN.
module stopwatch_ctrl #(
    parameter int unsigned PRESCALE = 50000000,
    parameter int unsigned PS_W     = 26
) (
    input logic             CLK,
    input logic             RST_N,
    stopwatch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    state_t          state, state_nxt;
    logic [PS_W-1:0] ps;
    logic [3:0]      u, t, h, th;
    logic [3:0]      u_n, t_n, h_n, th_n;
    logic            c0, c1, c2, c3;
    logic            count_en, adv;
    logic            tick_q, ovf_q;

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: clear > stop > start, levels sampled every edge
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (!bus.stop && bus.start) state_nxt = RUN;
                RUN:     if (bus.stop) state_nxt = PAUSE;
                PAUSE:   if (!bus.stop && bus.start) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM outputs: prescaler enable, advance strobe and ripple-carry next digits
    always_comb begin
        count_en = (state == RUN) && !bus.clear && !bus.stop;
        adv      = count_en && (ps == PS_LAST);
        c0       = (u == 4'd9);
        c1       = c0 && (t == 4'd9);
        c2       = c1 && (h == 4'd9);
        c3       = c2 && (th == 4'd9);
        u_n      = c0 ? 4'd0 : u + 4'd1;
        t_n      = c0 ? ((t == 4'd9) ? 4'd0 : t + 4'd1) : t;
        h_n      = c1 ? ((h == 4'd9) ? 4'd0 : h + 4'd1) : h;
        th_n     = c2 ? ((th == 4'd9) ? 4'd0 : th + 4'd1) : th;
    end

    // Prescaler, digit chain, tick pulse and sticky overflow
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ps     <= '0;
            u      <= '0;
            t      <= '0;
            h      <= '0;
            th     <= '0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (bus.clear) begin
            ps     <= '0;
            u      <= '0;
            t      <= '0;
            h      <= '0;
            th     <= '0;
            tick_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            tick_q <= adv;
            if (count_en) begin
                if (adv) ps <= '0;
                else     ps <= ps + 1'b1;
            end
            if (adv) begin
                u  <= u_n;
                t  <= t_n;
                h  <= h_n;
                th <= th_n;
                if (c3) ovf_q <= 1'b1;
            end
        end
    end

    assign bus.running  = (state == RUN);
    assign bus.tick     = tick_q;
    assign bus.overflow = ovf_q;

`ifdef LAP_HOLD_EN
    logic        lap_q;
    logic [15:0] snap;

    // Lap toggle in RUN; entering hold captures the digits currently displayed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lap_q <= 1'b0;
            snap  <= '0;
        end else if (bus.clear) begin
            lap_q <= 1'b0;
        end else if ((state == RUN) && bus.lap) begin
            lap_q <= !lap_q;
            if (!lap_q) snap <= {th, h, t, u};
        end
    end

    assign bus.lap_active = lap_q;
    assign {bus.thousands, bus.hundreds, bus.tens, bus.units} = lap_q ? snap : {th, h, t, u};
`else
    assign {bus.thousands, bus.hundreds, bus.tens, bus.units} = {th, h, t, u};
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: stimulus pushes the expected display
// for every advance; monitors pop and compare on each tick.
// Two instances: PRESCALE=4 for control scenarios, PRESCALE=1 for the wrap.
module tb_stopwatch_ctrl;
    logic CLK;
    logic RST_N;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [16:0] q4[$];
    logic [16:0] q1[$];

    stopwatch_ctrl_if ifa();
    stopwatch_ctrl_if ifb();

    stopwatch_ctrl #(.PRESCALE(4), .PS_W(3)) dut4 (.CLK(CLK), .RST_N(RST_N), .bus(ifa));
    stopwatch_ctrl #(.PRESCALE(1), .PS_W(1)) dut1 (.CLK(CLK), .RST_N(RST_N), .bus(ifb));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] bcd(input int n);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'((n / 1000) % 10);
        d2 = 4'((n / 100) % 10);
        d1 = 4'((n / 10) % 10);
        d0 = 4'(n % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drv_a(input logic s, input logic p, input logic c);
        ifa.start = s; ifa.stop = p; ifa.clear = c;
        step(1);
        ifa.start = 1'b0; ifa.stop = 1'b0; ifa.clear = 1'b0;
    endtask

    task automatic drv_b(input logic s, input logic p, input logic c);
        ifb.start = s; ifb.stop = p; ifb.clear = c;
        step(1);
        ifb.start = 1'b0; ifb.stop = 1'b0; ifb.clear = 1'b0;
    endtask

    function automatic logic [15:0] disp_a();
        return {ifa.thousands, ifa.hundreds, ifa.tens, ifa.units};
    endfunction

    function automatic logic [15:0] disp_b();
        return {ifb.thousands, ifb.hundreds, ifb.tens, ifb.units};
    endfunction

    // Monitor for the PRESCALE=4 instance
    always @(negedge CLK) begin
        if (RST_N && ifa.tick) begin
            if (q4.size() == 0) begin
                check("tick4_unexpected", 32'd1, 32'd0);
            end else begin
                check("tick4_display", {15'd0, disp_a(), ifa.overflow}, {15'd0, q4.pop_front()});
            end
        end
    end

    // Monitor for the PRESCALE=1 instance
    always @(negedge CLK) begin
        if (RST_N && ifb.tick) begin
            if (q1.size() == 0) begin
                check("tick1_unexpected", 32'd1, 32'd0);
            end else begin
                check("tick1_display", {15'd0, disp_b(), ifb.overflow}, {15'd0, q1.pop_front()});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        ifa.start = 1'b0; ifa.stop = 1'b0; ifa.clear = 1'b0;
        ifb.start = 1'b0; ifb.stop = 1'b0; ifb.clear = 1'b0;
`ifdef LAP_HOLD_EN
        ifa.lap = 1'b0;
        ifb.lap = 1'b0;
`endif
        step(3);
        check("rst_digits", {16'd0, disp_a()}, 32'd0);
        check("rst_running", {31'd0, ifa.running}, 32'd0);
        check("rst_tick", {31'd0, ifa.tick}, 32'd0);
        check("rst_overflow", {31'd0, ifa.overflow}, 32'd0);
        RST_N = 1'b1;
        step(10);
        check("idle_no_count", {16'd0, disp_a()}, 32'd0);
        check("idle_running", {31'd0, ifa.running}, 32'd0);

        // Basic count: 40 RUN edges after the start edge -> 0010
        drv_a(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) q4.push_back({bcd(i), 1'b0});
        step(3);
        check("basic_before_first_adv", {16'd0, disp_a()}, 32'd0);
        step(37);
        check("basic_display_10", {16'd0, disp_a()}, {16'd0, bcd(10)});
        check("basic_running", {31'd0, ifa.running}, 32'd1);

        // Pause/resume continues the partial prescaler period
        drv_a(1'b0, 1'b0, 1'b1);
        check("clear_digits", {16'd0, disp_a()}, 32'd0);
        check("clear_running", {31'd0, ifa.running}, 32'd0);
        drv_a(1'b1, 1'b0, 1'b0);
        q4.push_back({bcd(1), 1'b0});
        step(6);
        drv_a(1'b0, 1'b1, 1'b0);
        check("pause_running", {31'd0, ifa.running}, 32'd0);
        step(10);
        check("pause_hold", {16'd0, disp_a()}, {16'd0, bcd(1)});
        drv_a(1'b1, 1'b0, 1'b0);
        q4.push_back({bcd(2), 1'b0});
        step(1);
        check("resume_1st_edge", {16'd0, disp_a()}, {16'd0, bcd(1)});
        step(1);
        check("resume_2nd_edge", {16'd0, disp_a()}, {16'd0, bcd(2)});

        // Priority: all three in RUN -> IDLE and zero
        drv_a(1'b1, 1'b1, 1'b1);
        check("prio_all_running", {31'd0, ifa.running}, 32'd0);
        check("prio_all_digits", {16'd0, disp_a()}, 32'd0);
        drv_a(1'b0, 1'b1, 1'b0);
        check("stop_in_idle", {31'd0, ifa.running}, 32'd0);
        drv_a(1'b1, 1'b0, 1'b0);
        q4.push_back({bcd(1), 1'b0});
        step(5);
        drv_a(1'b0, 1'b1, 1'b0);
        drv_a(1'b1, 1'b1, 1'b0);
        check("pause_start_stop", {31'd0, ifa.running}, 32'd0);
        check("pause_start_stop_digits", {16'd0, disp_a()}, {16'd0, bcd(1)});
        drv_a(1'b1, 1'b0, 1'b0);
        q4.push_back({bcd(2), 1'b0});
        step(2);
        check("resume_partial_pre", {16'd0, disp_a()}, {16'd0, bcd(1)});
        step(1);
        check("resume_partial_adv", {16'd0, disp_a()}, {16'd0, bcd(2)});

        // Asynchronous reset mid-run at 0012
        drv_a(1'b0, 1'b0, 1'b1);
        drv_a(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 12; i++) q4.push_back({bcd(i), 1'b0});
        step(48);
        check("pre_reset_12", {16'd0, disp_a()}, {16'd0, bcd(12)});
        step(2);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_rst_digits", {16'd0, disp_a()}, 32'd0);
        check("async_rst_running", {31'd0, ifa.running}, 32'd0);
        step(1);
        RST_N = 1'b1;
        step(10);
        check("post_rst_idle", {16'd0, disp_a()}, 32'd0);
        check("post_rst_running", {31'd0, ifa.running}, 32'd0);
        check("q4_drained", q4.size(), 32'd0);

        // Wrap 9999 -> 0000 on the PRESCALE=1 instance
        drv_b(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 9999; i++) q1.push_back({bcd(i), 1'b0});
        q1.push_back({16'd0, 1'b1});
        step(9999);
        check("wrap_9999", {16'd0, disp_b()}, {16'd0, bcd(9999)});
        check("wrap_no_ovf_yet", {31'd0, ifb.overflow}, 32'd0);
        step(1);
        check("wrap_zero", {16'd0, disp_b()}, 32'd0);
        check("wrap_ovf", {31'd0, ifb.overflow}, 32'd1);
        drv_b(1'b0, 1'b0, 1'b1);
        check("clear_ovf", {31'd0, ifb.overflow}, 32'd0);
        check("clear_wrap_running", {31'd0, ifb.running}, 32'd0);
        step(2);
        check("q1_drained", q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Run/pause/clear controller that sequences a four-digit cascaded BCD decade counter (units, tens, hundreds, thousands) from a single fast clock. A prescaler derives the count-advance strobe. A three-state FSM driven by start/stop/clear pulses gates the prescaler. Digit outputs feed the display multiplexer directly.

Parameters:
PRESCALE, 50000000, CLK cycles per count advance; legal range 1 to 2^26.
PS_W, 26, prescaler register width; must satisfy 2^PS_W >= PRESCALE.

Ports:
CLK  input  1  system clock; all state updates on rising edge.
RST_N  input  1  asynchronous, active-low reset.
start  input  1  synchronous request to run; level sampled every edge.
stop  input  1  synchronous request to pause.
clear  input  1  synchronous request to zero and go idle.
units  output  4  BCD digit 0, range 0-9.
tens  output  4  BCD digit 1, range 0-9.
hundreds  output  4  BCD digit 2, range 0-9.
thousands  output  4  BCD digit 3, range 0-9.
running  output  1  high while the FSM is in RUN.
tick  output  1  registered one-cycle pulse on the cycle after each count advance.
overflow  output  1  sticky flag, set on wrap from 9999 to 0000.

Behaviour:
- Reset, asynchronous on RST_N low:
  - FSM to IDLE; prescaler 0.
  - All digits 0; running, tick and overflow 0.
  - Applies immediately, including mid-run.
- FSM states and transitions:
  - IDLE: start goes to RUN.
  - RUN: stop goes to PAUSE; start is ignored.
  - PAUSE: start goes to RUN; stop is ignored.
  - clear from any state goes to IDLE. It zeroes the digits, prescaler and overflow on that edge.
  - Input priority: clear > stop > start. Inputs are edge-sampled levels, not edge-detected. A held start keeps RUN.
- Prescaler:
  - Increments only on edges where state is RUN and neither clear nor stop is asserted.
  - On such an edge with prescaler == PRESCALE-1, the prescaler goes to 0 and the digits advance.
  - The prescaler holds its value in PAUSE. Resume continues the partial period.
  - The prescaler is zeroed only by reset or clear.
- Timing:
  - Entry into RUN happens on the edge that samples start. That edge does not count.
  - From IDLE, the first advance occurs on the PRESCALE-th subsequent RUN edge.
- Digit advance, ripple carry within one edge:
  - units+1. At 9, units goes to 0 and carries to tens, and so on up the chain.
  - 9999 goes to 0000 with overflow set to 1.
  - Digits never leave 0-9.
- tick is high for exactly one cycle following each advance edge.
- running reflects the registered FSM state.

Optional Feature:
Macro LAP_HOLD_EN. When defined:
- Adds input lap (1 bit) and output lap_active (1 bit, reset 0).
- A lap pulse sampled in RUN toggles lap_active.
- While lap_active=1, the digit outputs are frozen at the snapshot taken on the toggling edge. Internal counting, tick and overflow continue.
- A second lap releases the hold, and the outputs show the live count on the next cycle.
- lap in IDLE or PAUSE is ignored. clear and reset force lap_active to 0.

When undefined, the lap and lap_active ports do not exist and the digit outputs always show the live count.

Test Plan:
All scenarios use PRESCALE=4 unless stated.
1. Reset: RST_N low mid-RUN with digits 0012 -> all outputs 0 asynchronously and running=0. After release, no counting until start.
2. Basic count: start pulse at edge 0 -> units=1 after edge 4, tick high after edge 4. After 40 RUN edges, display 0010 (tens=1, units=0), running=1.
3. Pause/resume: start, 6 RUN edges (units=1, prescaler=2), stop -> digits unchanged for 10 cycles. Start again -> units=2 on the 2nd RUN edge after the resume edge.
4. Wrap: PRESCALE=1, start, 9999 RUN edges -> display 9999, overflow=0. Next edge -> 0000, overflow=1. clear -> overflow=0, IDLE.
5. Priority: start+stop+clear together in RUN -> IDLE, all zero. Start+stop together in PAUSE -> stays PAUSE. Stop in IDLE -> stays IDLE.
6. Lap (LAP_HOLD_EN defined): lap at display 0012 -> outputs hold 0012 for 20 advances while tick pulses. Second lap -> outputs show live 0032 next cycle.
